// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - ROM port sequencer: download writes, game reset hold, round-robin CPU/sound reads
// Define ROM_ARB_CHECKSUM_EN to build the download checksum on dl_sum.
module rom_port_arbiter #(
  parameter int                ADDR_W      = 17,
  parameter logic [ADDR_W-1:0] SND_BASE    = 17'h08000,
  parameter int                HOLD_CYCLES = 1024
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_download,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              cpu_req,
  input  logic [14:0]       cpu_addr,
  output logic              cpu_ack,
  output logic [7:0]        cpu_data,
  input  logic              snd_req,
  input  logic [13:0]       snd_addr,
  output logic              snd_ack,
  output logic [7:0]        snd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              game_reset,
  output logic [7:0]        dl_sum
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_HOLD, S_LOAD, S_RUN} top_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_CAPT} rd_t;

  top_t             r_state, w_state_nxt;
  rd_t              r_rd, w_rd_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic              r_last_snd;
  logic              r_cpu_ack, r_snd_ack, r_mem_we;
  logic [7:0]        r_cpu_data, r_snd_data, r_mem_din;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              w_load_entry, w_wr_accept, w_grant, w_pick_snd, w_done;
  logic [ADDR_W-1:0] w_snd_addr;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_HOLD;
      r_rd    <= R_IDLE;
      r_cnt   <= HOLD_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_rd    <= w_rd_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A download preempts everything, including a read already in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = r_rd;
    w_cnt_nxt   = r_cnt;
    if (dl_download) begin
      w_state_nxt = S_LOAD;
      w_rd_nxt    = R_IDLE;
    end else begin
      case (r_state)
        S_LOAD: begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = HOLD_INIT;
        end
        S_HOLD: begin
          if (r_cnt == '0) w_state_nxt = S_RUN;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        S_RUN: begin
          case (r_rd)
            R_IDLE:  if (cpu_req || snd_req) w_rd_nxt = R_ISSUE;
            R_ISSUE: w_rd_nxt = R_CAPT;
            default: w_rd_nxt = R_IDLE;
          endcase
        end
        default: w_state_nxt = S_HOLD;
      endcase
    end
  end

  always_comb begin
    w_load_entry = dl_download && (r_state != S_LOAD);
    w_wr_accept  = (r_state == S_LOAD) && dl_wr;
    w_grant      = !dl_download && (r_state == S_RUN) && (r_rd == R_IDLE) && (cpu_req || snd_req);
    w_pick_snd   = snd_req && (!cpu_req || !r_last_snd);
    w_done       = !dl_download && (r_state == S_RUN) && (r_rd == R_CAPT);
    w_snd_addr   = SND_BASE + ADDR_W'(snd_addr);
  end

  // r_last_snd doubles as "who owns the read in flight" once a grant is made.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_last_snd <= 1'b1;
      r_cpu_ack  <= 1'b0;
      r_snd_ack  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_cpu_data <= 8'h00;
      r_snd_data <= 8'h00;
      r_mem_din  <= 8'h00;
      r_mem_addr <= '0;
    end else begin
      r_mem_we  <= w_wr_accept;
      r_cpu_ack <= 1'b0;
      r_snd_ack <= 1'b0;
      if (w_wr_accept) begin
        r_mem_addr <= dl_addr;
        r_mem_din  <= dl_data;
      end else if (w_grant) begin
        r_mem_addr <= w_pick_snd ? w_snd_addr : ADDR_W'(cpu_addr);
        r_last_snd <= w_pick_snd;
      end
      if (w_done) begin
        if (r_last_snd) begin
          r_snd_ack  <= 1'b1;
          r_snd_data <= mem_dout;
        end else begin
          r_cpu_ack  <= 1'b1;
          r_cpu_data <= mem_dout;
        end
      end
    end
  end

`ifdef ROM_ARB_CHECKSUM_EN
  logic [7:0] r_dl_sum;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)         r_dl_sum <= 8'h00;
    else if (w_load_entry) r_dl_sum <= 8'h00;
    else if (w_wr_accept)  r_dl_sum <= r_dl_sum + dl_data;
  end

  assign dl_sum = r_dl_sum;
`else
  assign dl_sum = 8'h00;
`endif

  assign cpu_ack    = r_cpu_ack;
  assign snd_ack    = r_snd_ack;
  assign cpu_data   = r_cpu_data;
  assign snd_data   = r_snd_data;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_din    = r_mem_din;
  assign game_reset = (r_state != S_RUN);

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Sequences the single program/sound ROM block-RAM port in the arcade core. The port is shared between the HPS ROM download writer and two read requesters: the main CPU and the sound CPU. The block holds the game in reset during and after a download, then arbitrates CPU/sound reads round-robin with a request/ack handshake. It sits between `hps_io` download signals, the ROM RAM, and the game core's reset input.

## Interface

Parameters:
- `ADDR_W`, 17: ROM RAM address width.
- `SND_BASE`, 17'h08000: RAM offset of the sound ROM. The sound address is `SND_BASE + snd_addr`, truncated to `ADDR_W`.
- `HOLD_CYCLES`, 1024: `game_reset` stretch after a download ends or after `reset_n` is released. Must be at least 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk_sys`  in  1  system clock (40 MHz).
- `reset_n`  in  1  asynchronous active-low reset.
- `dl_download`  in  1  ROM download active; already qualified with index 0.
- `dl_wr`  in  1  download byte strobe.
- `dl_addr`  in  `ADDR_W`  download byte address.
- `dl_data`  in  8  download byte.
- `cpu_req`  in  1  CPU read request (level).
- `cpu_addr`  in  15  CPU ROM address.
- `cpu_ack`  out  1  one-cycle pulse; `cpu_data` is valid in the same cycle.
- `cpu_data`  out  8  CPU read data; held until the next CPU ack.
- `snd_req`  in  1  sound read request (level).
- `snd_addr`  in  14  sound ROM address.
- `snd_ack`  out  1  one-cycle pulse.
- `snd_data`  out  8  sound read data; held.
- `mem_addr`  out  `ADDR_W`  RAM address (registered).
- `mem_we`  out  1  RAM write enable (registered).
- `mem_din`  out  8  RAM write data (registered).
- `mem_dout`  in  8  RAM read data; 1-cycle synchronous read latency.
- `game_reset`  out  1  active-high reset to the game core.
- `dl_sum`  out  8  download checksum (see Configuration).

## Operation

- Top FSM states: HOLD, LOAD, RUN.
- **Reset**:
  - State goes to HOLD with the counter at `HOLD_CYCLES-1`.
  - `game_reset`=1.
  - All acks, `mem_we`, `mem_addr`, `mem_din`, `cpu_data`, `snd_data`, and `dl_sum` are 0.
  - The round-robin pointer is set to "sound last granted", so the CPU wins first.
- **HOLD**:
  - The counter decrements each cycle; at 0 the FSM enters RUN.
  - `game_reset` stays 1 through the cycle in which the counter reaches 0, and goes to 0 in RUN.
- **LOAD**:
  - Entered from any state when `dl_download`=1, which has priority over everything.
  - Any read in flight is abandoned and no ack is issued.
  - `game_reset`=1.
  - Each `dl_wr` produces one `mem_we` cycle on the next clock, with `mem_addr`=`dl_addr` and `mem_din`=`dl_data`.
  - When `dl_download`=0, the FSM enters HOLD with the counter reloaded.
- **RUN**: read sub-FSM with states IDLE, ISSUE, CAPT.
  - IDLE:
    - If any request is pending, select one. When both are pending, grant the requester opposite to the last granted one; the pointer updates on grant.
    - Register `mem_addr`: `{2'b00,cpu_addr}` for the CPU, or `SND_BASE+snd_addr` for sound.
    - Go to ISSUE.
  - ISSUE: wait for the RAM latency.
  - CAPT:
    - Register `mem_dout` into the granted data output and pulse its ack.
    - Return to IDLE.
- **Handshake**:
  - The requester holds `req` and its address stable until ack.
  - If `req` is still high in the cycle after ack, it is a new request.
  - A request dropped before ack is still completed and acked.
- `dl_wr` outside LOAD is ignored.

## Timing

- Read latency: request sampled high in IDLE at cycle T gives `mem_addr` valid in T+1, `mem_dout` valid in T+2, and ack plus data in T+3.
- Maximum throughput: one read per 3 cycles.
- Download write: `dl_wr` at cycle T gives `mem_we` in T+1. Back-to-back `dl_wr` strobes are supported.
- Download end: `dl_download` falling at T gives `game_reset` falling at T+1+`HOLD_CYCLES`.
- Assertion of `reset_n` clears all state asynchronously. This applies mid-download and mid-read; no ack is issued for the interrupted read.

## Configuration

`ROM_ARB_CHECKSUM_EN`:
- **Defined**: `dl_sum` clears on LOAD entry and adds `dl_data` modulo 256 on every accepted `dl_wr`. It holds its value after LOAD exits.
- **Undefined**: `dl_sum` is tied to 0 and the adder is not built.

## Test plan

- **Reset release**: with `HOLD_CYCLES`=4 and no requests, `game_reset`=1 for exactly 4 cycles after `reset_n` rises, then 0. All acks stay 0.
- **Download**: write bytes 0x11, 0x22, 0x33 to addresses 0..2 → `mem_we` pulses at T+1 with matching `mem_addr`/`mem_din`. `game_reset` falls `HOLD_CYCLES`+1 cycles after `dl_download` falls. `dl_sum`=0x66 with the macro, 0 without.
- **Single read**: `cpu_req` with `cpu_addr`=0x1234, and RAM[0x1234]=0xA5 → `cpu_ack` pulse 3 cycles later with `cpu_data`=0xA5.
- **Contention**: `cpu_req` and `snd_req` both held high from the same cycle → grants alternate CPU, SND, CPU. The sound address is 0x08000+`snd_addr`.
- **Abort**: `dl_download` rises in the ISSUE state of a sound read → no `snd_ack` and `game_reset`=1. A first `dl_wr` writes correctly.
- **Async reset mid-read**: `reset_n` low during CAPT → outputs clear immediately. No ack is issued and the FSM restarts in HOLD.
